// File: rtl/wram_arbiter_if.sv
// Memory-controller side of the WRAM arbiter.
// Level request held until a one-cycle acknowledge.
interface wram_mem_if #(
    parameter int AW = 17,
    parameter int DW = 8
);
    logic          MEM_REQ;
    logic          MEM_WE;
    logic [AW-1:0] MEM_A;
    logic [DW-1:0] MEM_D;
    logic          MEM_ACK;
    logic [DW-1:0] MEM_Q;

    modport master (
        output MEM_REQ, MEM_WE, MEM_A, MEM_D,
        input  MEM_ACK, MEM_Q
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_A, MEM_D,
        output MEM_ACK, MEM_Q
    );
endinterface

// File: rtl/wram_arbiter.sv
// WRAM arbiter: SNES strobe edges and host requests
// sequenced onto one req/ack memory port, SNES first.
module wram_arbiter #(
    parameter int AW = 17,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ENABLE,
    input  logic [AW-1:0] SNES_A,
    input  logic [DW-1:0] SNES_D,
    input  logic          SNES_RD_N,
    input  logic          SNES_WE_N,
    output logic [DW-1:0] SNES_Q,
    input  logic          HOST_REQ,
    input  logic          HOST_WE,
    input  logic [AW-1:0] HOST_A,
    input  logic [DW-1:0] HOST_D,
    output logic          HOST_ACK,
    output logic [DW-1:0] HOST_Q,
    wram_mem_if.master    mem,
    output logic          BUSY,
    output logic          OVERRUN
);
    typedef enum logic [1:0] {IDLE, SNES_ACC, HOST_ACC} state_t;

    state_t        state_q, state_d;
    logic          rd_n_q, we_n_q;
    logic          snes_pend_q, snes_pend_d;
    logic [AW-1:0] slot_a_q, slot_a_d;
    logic [DW-1:0] slot_d_q, slot_d_d;
    logic          slot_we_q, slot_we_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_d_q, mem_d_d;
    logic          host_ack_q, host_ack_d;
    logic [DW-1:0] host_q_q, host_q_d;
    logic [DW-1:0] snes_q_q, snes_q_d;
    logic          overrun_q, overrun_d;

    logic rd_fall, we_fall, snes_edge;

    // Strobe falling edges; a write edge wins over a read edge.
    assign rd_fall   = rd_n_q & ~SNES_RD_N;
    assign we_fall   = we_n_q & ~SNES_WE_N;
    assign snes_edge = ENABLE & (rd_fall | we_fall);

    // Next-state: arbitration FSM, SNES slot capture, overrun detect.
    always_comb begin
        state_d     = state_q;
        snes_pend_d = snes_pend_q;
        slot_a_d    = slot_a_q;
        slot_d_d    = slot_d_q;
        slot_we_d   = slot_we_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_a_d     = mem_a_q;
        mem_d_d     = mem_d_q;
        host_ack_d  = 1'b0;
        host_q_d    = host_q_q;
        snes_q_d    = snes_q_q;
        overrun_d   = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (snes_pend_q) begin
                    state_d     = SNES_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = slot_we_q;
                    mem_a_d     = slot_a_q;
                    mem_d_d     = slot_d_q;
                    snes_pend_d = 1'b0;
                end else if (HOST_REQ && !host_ack_q) begin
                    state_d   = HOST_ACC;
                    mem_req_d = 1'b1;
                    mem_we_d  = HOST_WE;
                    mem_a_d   = HOST_A;
                    mem_d_d   = HOST_D;
                end
            end
            SNES_ACC: begin
                if (mem.MEM_ACK) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) snes_q_d = mem.MEM_Q;
                end
            end
            HOST_ACC: begin
                if (mem.MEM_ACK) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    host_ack_d = 1'b1;
                    if (!mem_we_q) host_q_d = mem.MEM_Q;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Slot is free again once issued above, so only an
        // unissued pending request counts as lost.
        if (snes_edge) begin
            if (snes_pend_d) overrun_d = 1'b1;
            snes_pend_d = 1'b1;
            slot_a_d    = SNES_A;
            slot_d_d    = SNES_D;
            slot_we_d   = we_fall;
        end
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            rd_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            snes_pend_q <= 1'b0;
            slot_a_q    <= '0;
            slot_d_q    <= '0;
            slot_we_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_d_q     <= '0;
            host_ack_q  <= 1'b0;
            host_q_q    <= '0;
            snes_q_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_n_q      <= SNES_RD_N;
            we_n_q      <= SNES_WE_N;
            snes_pend_q <= snes_pend_d;
            slot_a_q    <= slot_a_d;
            slot_d_q    <= slot_d_d;
            slot_we_q   <= slot_we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_a_q     <= mem_a_d;
            mem_d_q     <= mem_d_d;
            host_ack_q  <= host_ack_d;
            host_q_q    <= host_q_d;
            snes_q_q    <= snes_q_d;
            overrun_q   <= overrun_d;
        end
    end

    // Output mapping.
    assign mem.MEM_REQ = mem_req_q;
    assign mem.MEM_WE  = mem_we_q;
    assign mem.MEM_A   = mem_a_q;
    assign mem.MEM_D   = mem_d_q;
    assign SNES_Q      = snes_q_q;
    assign HOST_Q      = host_q_q;
    assign HOST_ACK    = host_ack_q;
    assign OVERRUN     = overrun_q;
    assign BUSY        = (state_q != IDLE) | snes_pend_q;
endmodule

// File: tb/tb_wram_arbiter.sv
// Directed bench for wram_arbiter.
// Inputs driven and outputs sampled on the falling edge.
module tb_wram_arbiter;
    logic        clk = 1'b0;
    logic        RST_N, ENABLE;
    logic [16:0] SNES_A, HOST_A;
    logic [7:0]  SNES_D, HOST_D, SNES_Q, HOST_Q;
    logic        SNES_RD_N, SNES_WE_N;
    logic        HOST_REQ, HOST_WE, HOST_ACK;
    logic        BUSY, OVERRUN;
    int          checks = 0;
    int          failures = 0;

    wram_mem_if #(.AW(17), .DW(8)) mem_bus();

    wram_arbiter #(.AW(17), .DW(8)) dut (
        .CLK(clk), .RST_N(RST_N), .ENABLE(ENABLE),
        .SNES_A(SNES_A), .SNES_D(SNES_D),
        .SNES_RD_N(SNES_RD_N), .SNES_WE_N(SNES_WE_N),
        .SNES_Q(SNES_Q), .HOST_REQ(HOST_REQ),
        .HOST_WE(HOST_WE), .HOST_A(HOST_A),
        .HOST_D(HOST_D), .HOST_ACK(HOST_ACK),
        .HOST_Q(HOST_Q), .mem(mem_bus),
        .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic ack(input logic [7:0] q);
        mem_bus.MEM_Q   = q;
        mem_bus.MEM_ACK = 1'b1;
        step();
        mem_bus.MEM_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) step();
        checks++;
        if ({mem_bus.MEM_REQ, BUSY, HOST_ACK, OVERRUN} !== 4'b0) begin
            failures++;
            $display("FAIL rst_flags: got %b want 0000",
                {mem_bus.MEM_REQ, BUSY, HOST_ACK, OVERRUN});
        end
        checks++;
        if ({SNES_Q, HOST_Q} !== 16'h0) begin
            failures++;
            $display("FAIL rst_q: got %h want 0000", {SNES_Q, HOST_Q});
        end
        checks++;
        if ({mem_bus.MEM_WE, mem_bus.MEM_A, mem_bus.MEM_D} !== 26'h0) begin
            failures++;
            $display("FAIL rst_mem: got %h want 0",
                {mem_bus.MEM_WE, mem_bus.MEM_A, mem_bus.MEM_D});
        end
        RST_N = 1'b1;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, BUSY} !== 2'b00) begin
            failures++;
            $display("FAIL rst_noedge: got %b want 00",
                {mem_bus.MEM_REQ, BUSY});
        end
    endtask

    task automatic test_snes_write();
        SNES_A = 17'h1FFFF; SNES_D = 8'h5A; SNES_WE_N = 1'b0;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, BUSY} !== 2'b01) begin
            failures++;
            $display("FAIL wr_capture: req,busy got %b want 01",
                {mem_bus.MEM_REQ, BUSY});
        end
        SNES_WE_N = 1'b1;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_A,
             mem_bus.MEM_D} !== {2'b11, 17'h1FFFF, 8'h5A}) begin
            failures++;
            $display("FAIL wr_issue: got %b%b %h %h want 11 1ffff 5a",
                mem_bus.MEM_REQ, mem_bus.MEM_WE,
                mem_bus.MEM_A, mem_bus.MEM_D);
        end
        step();
        step();
        checks++;
        if ({mem_bus.MEM_REQ, BUSY, mem_bus.MEM_A}
            !== {2'b11, 17'h1FFFF}) begin
            failures++;
            $display("FAIL wr_hold: got %b%b %h want 11 1ffff",
                mem_bus.MEM_REQ, BUSY, mem_bus.MEM_A);
        end
        ack(8'h00);
        checks++;
        if ({mem_bus.MEM_REQ, BUSY} !== 2'b00) begin
            failures++;
            $display("FAIL wr_done: req,busy got %b want 00",
                {mem_bus.MEM_REQ, BUSY});
        end
    endtask

    task automatic test_snes_read();
        SNES_A = 17'h00010; SNES_RD_N = 1'b0;
        step();
        SNES_RD_N = 1'b1;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_A}
            !== {2'b10, 17'h00010}) begin
            failures++;
            $display("FAIL rd_issue: got %b%b %h want 10 00010",
                mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_A);
        end
        ack(8'hC3);
        checks++;
        if ({mem_bus.MEM_REQ, SNES_Q} !== {1'b0, 8'hC3}) begin
            failures++;
            $display("FAIL rd_data: got %b %h want 0 c3",
                mem_bus.MEM_REQ, SNES_Q);
        end
    endtask

    task automatic test_host_then_snes();
        HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_A = 17'h00400;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_A}
            !== {2'b10, 17'h00400}) begin
            failures++;
            $display("FAIL hs_host_issue: got %b%b %h want 10 00400",
                mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_A);
        end
        SNES_A = 17'h00123; SNES_D = 8'h77; SNES_WE_N = 1'b0;
        step();
        SNES_WE_N = 1'b1;
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_A} !== {1'b1, 17'h00400}) begin
            failures++;
            $display("FAIL hs_nopreempt: got %b %h want 1 00400",
                mem_bus.MEM_REQ, mem_bus.MEM_A);
        end
        ack(8'h9E);
        checks++;
        if ({HOST_ACK, HOST_Q, mem_bus.MEM_REQ}
            !== {1'b1, 8'h9E, 1'b0}) begin
            failures++;
            $display("FAIL hs_host_ack: got %b %h %b want 1 9e 0",
                HOST_ACK, HOST_Q, mem_bus.MEM_REQ);
        end
        HOST_REQ = 1'b0;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_A,
             mem_bus.MEM_D, HOST_ACK}
            !== {2'b11, 17'h00123, 8'h77, 1'b0}) begin
            failures++;
            $display("FAIL hs_snes_issue: got %b%b %h %h %b want 11 00123 77 0",
                mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_A,
                mem_bus.MEM_D, HOST_ACK);
        end
        ack(8'h00);
        checks++;
        if ({SNES_Q, HOST_Q, OVERRUN} !== {8'hC3, 8'h9E, 1'b0}) begin
            failures++;
            $display("FAIL hs_hold: got %h %h %b want c3 9e 0",
                SNES_Q, HOST_Q, OVERRUN);
        end
    endtask

    task automatic test_priority();
        SNES_A = 17'h00200; SNES_D = 8'h22; SNES_WE_N = 1'b0;
        step();
        SNES_WE_N = 1'b1;
        HOST_REQ = 1'b1; HOST_WE = 1'b1;
        HOST_A = 17'h00055; HOST_D = 8'h11;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_A, mem_bus.MEM_D}
            !== {1'b1, 17'h00200, 8'h22}) begin
            failures++;
            $display("FAIL pri_snes_first: got %b %h %h want 1 00200 22",
                mem_bus.MEM_REQ, mem_bus.MEM_A, mem_bus.MEM_D);
        end
        ack(8'h00);
        checks++;
        if (mem_bus.MEM_REQ !== 1'b0) begin
            failures++;
            $display("FAIL pri_gap: MEM_REQ got %b want 0",
                mem_bus.MEM_REQ);
        end
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_A,
             mem_bus.MEM_D} !== {2'b11, 17'h00055, 8'h11}) begin
            failures++;
            $display("FAIL pri_host_next: got %b%b %h %h want 11 00055 11",
                mem_bus.MEM_REQ, mem_bus.MEM_WE,
                mem_bus.MEM_A, mem_bus.MEM_D);
        end
        ack(8'h00);
        HOST_REQ = 1'b0;
        checks++;
        if ({HOST_ACK, HOST_Q} !== {1'b1, 8'h9E}) begin
            failures++;
            $display("FAIL pri_wr_ack: got %b %h want 1 9e",
                HOST_ACK, HOST_Q);
        end
        step();
        checks++;
        if (HOST_ACK !== 1'b0) begin
            failures++;
            $display("FAIL pri_ack_pulse: HOST_ACK got %b want 0",
                HOST_ACK);
        end
    endtask

    task automatic test_overrun();
        HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_A = 17'h00777;
        step();
        SNES_A = 17'h00AAA; SNES_D = 8'hA1; SNES_WE_N = 1'b0;
        step();
        SNES_WE_N = 1'b1;
        checks++;
        if (OVERRUN !== 1'b0) begin
            failures++;
            $display("FAIL ov_first: OVERRUN got %b want 0", OVERRUN);
        end
        step();
        SNES_A = 17'h00BBB; SNES_D = 8'hB2; SNES_WE_N = 1'b0;
        step();
        SNES_WE_N = 1'b1;
        checks++;
        if ({OVERRUN, mem_bus.MEM_A} !== {1'b1, 17'h00777}) begin
            failures++;
            $display("FAIL ov_set: got %b %h want 1 00777",
                OVERRUN, mem_bus.MEM_A);
        end
        ack(8'h44);
        HOST_REQ = 1'b0;
        checks++;
        if ({HOST_ACK, HOST_Q} !== {1'b1, 8'h44}) begin
            failures++;
            $display("FAIL ov_host_ack: got %b %h want 1 44",
                HOST_ACK, HOST_Q);
        end
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_A, mem_bus.MEM_D}
            !== {1'b1, 17'h00BBB, 8'hB2}) begin
            failures++;
            $display("FAIL ov_second: got %b %h %h want 1 00bbb b2",
                mem_bus.MEM_REQ, mem_bus.MEM_A, mem_bus.MEM_D);
        end
        ack(8'h00);
        repeat (3) step();
        checks++;
        if ({mem_bus.MEM_REQ, BUSY, OVERRUN} !== 3'b001) begin
            failures++;
            $display("FAIL ov_lost: got %b want 001",
                {mem_bus.MEM_REQ, BUSY, OVERRUN});
        end
    endtask

    task automatic test_disabled();
        int bad = 0;
        ENABLE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            SNES_RD_N = i[0];
            SNES_WE_N = i[1];
            step();
            if (mem_bus.MEM_REQ !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        SNES_RD_N = 1'b1; SNES_WE_N = 1'b1;
        step();
        if (mem_bus.MEM_REQ !== 1'b0 || BUSY !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL dis_no_snes: active cycles got %0d want 0", bad);
        end
        ack(8'h55);
        checks++;
        if ({HOST_ACK, SNES_Q, HOST_Q} !== {1'b0, 8'hC3, 8'h44}) begin
            failures++;
            $display("FAIL idle_ack_ignored: got %b %h %h want 0 c3 44",
                HOST_ACK, SNES_Q, HOST_Q);
        end
        HOST_REQ = 1'b1; HOST_WE = 1'b1;
        HOST_A = 17'h00100; HOST_D = 8'hAB;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_A, mem_bus.MEM_D}
            !== {1'b1, 17'h00100, 8'hAB}) begin
            failures++;
            $display("FAIL b2b_first: got %b %h %h want 1 00100 ab",
                mem_bus.MEM_REQ, mem_bus.MEM_A, mem_bus.MEM_D);
        end
        ack(8'h00);
        HOST_A = 17'h00101; HOST_D = 8'hCD;
        checks++;
        if ({HOST_ACK, mem_bus.MEM_REQ} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_ack1: got %b want 10",
                {HOST_ACK, mem_bus.MEM_REQ});
        end
        step();
        checks++;
        if ({HOST_ACK, mem_bus.MEM_REQ} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_no_reissue: got %b want 00",
                {HOST_ACK, mem_bus.MEM_REQ});
        end
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_A, mem_bus.MEM_D}
            !== {1'b1, 17'h00101, 8'hCD}) begin
            failures++;
            $display("FAIL b2b_second: got %b %h %h want 1 00101 cd",
                mem_bus.MEM_REQ, mem_bus.MEM_A, mem_bus.MEM_D);
        end
        ack(8'h00);
        HOST_REQ = 1'b0;
        checks++;
        if (HOST_ACK !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ack2: HOST_ACK got %b want 1", HOST_ACK);
        end
        step();
        ENABLE = 1'b1;
    endtask

    task automatic test_reset_mid();
        HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_A = 17'h00300;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, mem_bus.MEM_A} !== {1'b1, 17'h00300}) begin
            failures++;
            $display("FAIL rm_issue: got %b %h want 1 00300",
                mem_bus.MEM_REQ, mem_bus.MEM_A);
        end
        RST_N = 1'b0;
        mem_bus.MEM_Q = 8'h66;
        step();
        checks++;
        if ({mem_bus.MEM_REQ, BUSY, HOST_ACK, OVERRUN, SNES_Q, HOST_Q}
            !== 20'h0) begin
            failures++;
            $display("FAIL rm_state: got %b%b%b%b %h %h want 0000 00 00",
                mem_bus.MEM_REQ, BUSY, HOST_ACK, OVERRUN, SNES_Q, HOST_Q);
        end
        HOST_REQ = 1'b0;
        step();
        RST_N = 1'b1;
        step();
        checks++;
        if ({HOST_ACK, mem_bus.MEM_REQ, BUSY} !== 3'b000) begin
            failures++;
            $display("FAIL rm_after: got %b want 000",
                {HOST_ACK, mem_bus.MEM_REQ, BUSY});
        end
    endtask

    initial begin
        RST_N = 1'b0; ENABLE = 1'b1;
        SNES_A = '0; SNES_D = '0;
        SNES_RD_N = 1'b1; SNES_WE_N = 1'b1;
        HOST_REQ = 1'b0; HOST_WE = 1'b0;
        HOST_A = '0; HOST_D = '0;
        mem_bus.MEM_ACK = 1'b0; mem_bus.MEM_Q = '0;
        test_reset();
        test_snes_write();
        test_snes_read();
        test_host_then_snes();
        test_priority();
        test_overrun();
        test_disabled();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
